// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 access codes, fault causes.
// Misalignment helper is only referenced when LSU_MISALIGN_CHECK_EN is defined.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_ILLEGAL  = 2'b11;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // funct3[1:0] encodes size: 00 byte, 01 half, 10 word
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane select and sign/zero extension of the raw bus word.
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        case (funct3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data = {24'h000000, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data = {16'h0000, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding bus access with timeout, lane steering and load extension.
// Optional misalignment faulting is enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] RD,
    output logic        Stall,
    output logic        Done,
    output logic        Fault,
    output logic [1:0]  FaultCause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [CW-1:0] cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] ext_data;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        misaligned;

    load_extend u_load_extend (
        .funct3 (f3_q),
        .offset (off_q),
        .rdata  (bus_rdata),
        .data   (ext_data)
    );

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = WriteData;
        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ALUResult[1:0];
                wdata_d = {4{WriteData[7:0]}};
            end
            2'b01: begin
                be_d    = ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{WriteData[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = WriteData;
            end
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = f3_misaligned(funct3, ALUResult[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign Stall = MemReq && (state != DONE);

    // Bus signals are captured once on acceptance and held untouched until ack or timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            f3_q       <= F3_B;
            off_q      <= 2'b00;
            RD         <= '0;
            Done       <= 1'b0;
            Fault      <= 1'b0;
            FaultCause <= FC_NONE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done       <= 1'b0;
                    Fault      <= 1'b0;
                    FaultCause <= FC_NONE;
                    if (MemReq) begin
                        if (!f3_legal(funct3)) begin
                            state      <= DONE;
                            Done       <= 1'b1;
                            Fault      <= 1'b1;
                            FaultCause <= FC_ILLEGAL;
                        end else if (misaligned) begin
                            state      <= DONE;
                            Done       <= 1'b1;
                            Fault      <= 1'b1;
                            FaultCause <= FC_MISALIGN;
                        end else begin
                            state     <= ACCESS;
                            cnt       <= '0;
                            f3_q      <= funct3;
                            off_q     <= ALUResult[1:0];
                            bus_req   <= 1'b1;
                            bus_we    <= MemWrite;
                            bus_addr  <= {ALUResult[31:2], 2'b00};
                            bus_be    <= be_d;
                            bus_wdata <= MemWrite ? wdata_d : 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            RD <= ext_data;
                        end
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        Done    <= 1'b1;
                        state   <= DONE;
                    end else if (cnt == LAST_CYCLE) begin
                        RD         <= '0;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        Done       <= 1'b1;
                        Fault      <= 1'b1;
                        FaultCause <= FC_TIMEOUT;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    Done       <= 1'b0;
                    Fault      <= 1'b0;
                    FaultCause <= FC_NONE;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit; expected completions are queued at request time.
// Misalignment expectations follow LSU_MISALIGN_CHECK_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemReq = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] RD;
    logic        Stall;
    logic        Done;
    logic        Fault;
    logic [1:0]  FaultCause;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb[$];

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReq     (MemReq),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .RD         (RD),
        .Stall      (Stall),
        .Done       (Done),
        .Fault      (Fault),
        .FaultCause (FaultCause),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input exp_t e);
        MemReq    = 1'b1;
        MemWrite  = we;
        funct3    = f3;
        ALUResult = a;
        WriteData = wd;
        sb.push_back(e);
    endtask

    task automatic endRequest;
        MemReq  = 1'b0;
        bus_ack = 1'b0;
    endtask

    task automatic scoreDone(input string tag);
        exp_t e;
        checkOutput({tag, "_done"}, {31'b0, Done}, 32'd1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL %s_sb observed=completion expected=no completion", tag);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_rd"}, RD, e.rd);
            checkOutput({tag, "_fault"}, {31'b0, Fault}, {31'b0, e.fault});
            checkOutput({tag, "_cause"}, {30'b0, FaultCause}, {30'b0, e.cause});
        end
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (Done !== 1'b1 && n < budget) begin
            tick;
            n++;
        end
        scoreDone(tag);
    endtask

    initial begin
        int acc;
        int n;

        // Reset values while rst_n is held low
        #12;
        checkOutput("rst_rd", RD, 32'h0);
        checkOutput("rst_done", {31'b0, Done}, 32'd0);
        checkOutput("rst_fault", {31'b0, Fault}, 32'd0);
        checkOutput("rst_cause", {30'b0, FaultCause}, 32'd0);
        checkOutput("rst_req", {31'b0, bus_req}, 32'd0);
        checkOutput("rst_we", {31'b0, bus_we}, 32'd0);
        checkOutput("rst_be", {28'b0, bus_be}, 32'd0);
        checkOutput("rst_addr", bus_addr, 32'h0);
        checkOutput("rst_wdata", bus_wdata, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick;

        // LB with zero-wait ack: three-cycle latency
        bus_rdata = 32'h80FF_FF00;
        applyStimulus(1'b0, 3'b000, 32'h0000_1003, 32'h0, '{32'hFFFF_FF80, 1'b0, 2'b00});
        #1;
        checkOutput("lb_c1_stall", {31'b0, Stall}, 32'd1);
        checkOutput("lb_c1_req", {31'b0, bus_req}, 32'd0);
        tick;
        checkOutput("lb_c2_stall", {31'b0, Stall}, 32'd1);
        checkOutput("lb_c2_req", {31'b0, bus_req}, 32'd1);
        checkOutput("lb_c2_addr", bus_addr, 32'h0000_1000);
        checkOutput("lb_c2_done", {31'b0, Done}, 32'd0);
        bus_ack = 1'b1;
        tick;
        checkOutput("lb_c3_stall", {31'b0, Stall}, 32'd0);
        checkOutput("lb_c3_req", {31'b0, bus_req}, 32'd0);
        scoreDone("lb");
        endRequest;
        tick;

        // SH on the upper half
        applyStimulus(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, '{32'hFFFF_FF80, 1'b0, 2'b00});
        tick;
        checkOutput("sh_be", {28'b0, bus_be}, 32'h0000_000C);
        checkOutput("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
        checkOutput("sh_we", {31'b0, bus_we}, 32'd1);
        checkOutput("sh_addr", bus_addr, 32'h0000_2000);
        bus_ack = 1'b1;
        waitDone("sh", 4);
        endRequest;
        tick;

        // LW with four wait cycles: bus must hold still
        bus_rdata = 32'h1234_5678;
        applyStimulus(1'b0, 3'b010, 32'h0000_4008, 32'h0, '{32'h1234_5678, 1'b0, 2'b00});
        tick;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("lw_wait%0d_req", i), {31'b0, bus_req}, 32'd1);
            checkOutput($sformatf("lw_wait%0d_addr", i), bus_addr, 32'h0000_4008);
            checkOutput($sformatf("lw_wait%0d_be", i), {28'b0, bus_be}, 32'h0000_000F);
            checkOutput($sformatf("lw_wait%0d_we", i), {31'b0, bus_we}, 32'd0);
            checkOutput($sformatf("lw_wait%0d_done", i), {31'b0, Done}, 32'd0);
            if (i < 4) tick;
        end
        bus_ack = 1'b1;
        waitDone("lw_wait", 3);
        endRequest;
        // Ack in IDLE must not disturb RD
        bus_ack = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        tick;
        checkOutput("lw_done_one_cycle", {31'b0, Done}, 32'd0);
        tick;
        checkOutput("idle_ack_rd", RD, 32'h1234_5678);
        checkOutput("idle_ack_req", {31'b0, bus_req}, 32'd0);
        bus_ack = 1'b0;

        // SB into byte lane 1
        applyStimulus(1'b1, 3'b000, 32'h0000_5001, 32'h0000_00A5, '{32'h1234_5678, 1'b0, 2'b00});
        tick;
        checkOutput("sb_be", {28'b0, bus_be}, 32'h0000_0002);
        checkOutput("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
        bus_ack = 1'b1;
        waitDone("sb", 4);
        endRequest;
        tick;

        // LBU lane 2, LHU upper half, LH lower half
        bus_rdata = 32'h11AB_2233;
        applyStimulus(1'b0, 3'b100, 32'h0000_6002, 32'h0, '{32'h0000_00AB, 1'b0, 2'b00});
        tick;
        bus_ack = 1'b1;
        waitDone("lbu", 4);
        endRequest;
        tick;
        bus_rdata = 32'h8001_0000;
        applyStimulus(1'b0, 3'b101, 32'h0000_7002, 32'h0, '{32'h0000_8001, 1'b0, 2'b00});
        tick;
        bus_ack = 1'b1;
        waitDone("lhu", 4);
        endRequest;
        tick;
        bus_rdata = 32'h1234_F00D;
        applyStimulus(1'b0, 3'b001, 32'h0000_7000, 32'h0, '{32'hFFFF_F00D, 1'b0, 2'b00});
        tick;
        bus_ack = 1'b1;
        waitDone("lh", 4);
        endRequest;
        tick;

        // Illegal funct3 never reaches the bus
        applyStimulus(1'b0, 3'b011, 32'h0000_1000, 32'h0, '{32'hFFFF_F00D, 1'b1, 2'b11});
        tick;
        checkOutput("ill_req", {31'b0, bus_req}, 32'd0);
        scoreDone("ill");
        endRequest;
        tick;

        // Timeout after 16 ACCESS cycles without ack
        applyStimulus(1'b0, 3'b010, 32'h0000_8000, 32'h0, '{32'h0, 1'b1, 2'b10});
        tick;
        acc = 0;
        n = 0;
        while (Done !== 1'b1 && n < 40) begin
            if (bus_req === 1'b1) acc++;
            n++;
            tick;
        end
        checkOutput("to_access_cycles", acc, 32'd16);
        checkOutput("to_req", {31'b0, bus_req}, 32'd0);
        scoreDone("to");
        endRequest;
        tick;

        // Odd-address LH
        bus_rdata = 32'hCAFE_8001;
`ifdef LSU_MISALIGN_CHECK_EN
        applyStimulus(1'b0, 3'b001, 32'h0000_3001, 32'h0, '{32'h0, 1'b1, 2'b01});
        tick;
        checkOutput("mis_req", {31'b0, bus_req}, 32'd0);
        scoreDone("mis");
`else
        applyStimulus(1'b0, 3'b001, 32'h0000_3001, 32'h0, '{32'hFFFF_8001, 1'b0, 2'b00});
        tick;
        checkOutput("mis_req", {31'b0, bus_req}, 32'd1);
        checkOutput("mis_be", {28'b0, bus_be}, 32'h0000_0003);
        bus_ack = 1'b1;
        waitDone("mis", 4);
`endif
        endRequest;
        tick;

        // Reset during ACCESS drops bus_req without waiting for a clock
        MemReq    = 1'b1;
        MemWrite  = 1'b0;
        funct3    = 3'b010;
        ALUResult = 32'h0000_9000;
        tick;
        checkOutput("rma_req_before", {31'b0, bus_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rma_req_async", {31'b0, bus_req}, 32'd0);
        checkOutput("rma_done", {31'b0, Done}, 32'd0);
        checkOutput("rma_rd", RD, 32'h0);
        MemReq = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        checkOutput("rma_post_done", {31'b0, Done}, 32'd0);
        checkOutput("rma_post_req", {31'b0, bus_req}, 32'd0);
        checkOutput("rma_post_stall", {31'b0, Stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS cycles awaiting bus_ack before fault.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 MemReq  input  1  core requests load/store this instruction.
REQ-005 MemWrite  input  1  1=store, 0=load.
REQ-006 funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 ALUResult  input  32  byte address.
REQ-008 WriteData  input  32  store data (rs2).
REQ-009 RD  output  32  extended load data to result-select stage.
REQ-010 Stall  output  1  freeze PC/core while access outstanding.
REQ-011 Done  output  1  one-cycle completion pulse.
REQ-012 Fault  output  1  asserted with Done on abnormal completion.
REQ-013 FaultCause  output  2  00 none, 01 misaligned, 10 timeout, 11 illegal funct3.
REQ-014 bus_req, bus_we  output  1 each  bus request / write.
REQ-015 bus_addr  output  32  word-aligned address ({ALUResult[31:2],2'b00}).
REQ-016 bus_wdata  output  32; bus_be  output  4  lane-positioned data and byte enables.
REQ-017 bus_rdata  input  32; bus_ack  input  1  read data / completion, valid same cycle.

Function
REQ-018 FSM states IDLE, ACCESS, DONE.
REQ-019 IDLE and MemReq=1, legal, aligned: latch address/data/funct3/MemWrite -> ACCESS; bus_req=1 from next cycle.
REQ-020 ACCESS: bus_req, bus_we, bus_addr, bus_wdata, bus_be held stable until bus_ack sampled 1.
REQ-021 bus_ack in ACCESS: loads capture extended bus_rdata into RD; -> DONE.
REQ-022 DONE: Done=1 for exactly one cycle, unconditionally -> IDLE; no new request accepted in DONE.
REQ-023 Stall = MemReq && (state != DONE), combinational.
REQ-024 Minimum latency: request cycle + 1 ACCESS + 1 DONE = 3 cycles with zero-wait ack.
REQ-025 Timeout counter clears on entering ACCESS; reaching TIMEOUT_CYCLES without ack -> DONE with Fault=1, FaultCause=10, RD=0, bus_req dropped.
REQ-026 Illegal funct3 (011,110,111) in IDLE: no bus cycle, -> DONE with FaultCause=11.
REQ-027 Load extension: B/H sign-extend, BU/HU zero-extend; lane chosen by ALUResult[1:0] (byte) or ALUResult[1] (half).
REQ-028 Store: SB be=0001<<a[1:0], wdata byte replicated x4; SH be=0011<<(2*a[1]), half replicated x2; SW be=1111.
REQ-029 RD holds last completed load value; stores and faults other than timeout leave RD unchanged.
REQ-030 Ack arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-031 rst_n low: state IDLE, RD=0, Done=0, Fault=0, FaultCause=00, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, counter=0.
REQ-032 Reset mid-ACCESS SHALL drop bus_req immediately (asynchronous); no Done issued.

Configuration
REQ-033 Macro LSU_MISALIGN_CHECK_EN defined: half on odd address or word with a[1:0]!=00 -> no bus cycle, DONE with FaultCause=01.
REQ-034 Macro absent: no misalignment check; address low bits ignored beyond lane selection (half uses a[1], word uses none); FaultCause=01 never produced.

Structure
REQ-035 Package lsu_pkg: FSM state enum, funct3 size constants, FaultCause codes.
REQ-036 Sub-module load_extend: combinational lane select plus sign/zero extension, instantiated once.

Verification
REQ-037 LB a=0x1003, rdata=0x80FF_FF00, ack 1st cycle -> RD=0xFFFF_FF80, Done on cycle 3, Stall high cycles 1-2.
REQ-038 SH a=0x2002, WriteData=0x0000_BEEF -> bus_be=1100, bus_wdata=0xBEEF_BEEF, bus_we=1.
REQ-039 LW, ack after 4 wait cycles -> bus signals stable throughout; RD=rdata; Done exactly one cycle.
REQ-040 LW, no ack -> after 16 ACCESS cycles Fault=1, FaultCause=10, RD=0, bus_req=0.
REQ-041 LH a=0x3001 with LSU_MISALIGN_CHECK_EN -> no bus_req, FaultCause=01; without it -> LH on lane 0 completes normally.
REQ-042 rst_n low during ACCESS -> bus_req=0 same cycle, state IDLE, no Done.
